// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset PC default, NOP encoding and the
// fetch queue entry layout.
package cpu_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic               filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: slot storage plus alloc/fill/rd pointers (wrap-bit style) and flush.
// Slots are reserved at request time and filled in order as responses return.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = $clog2(Depth) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               alloc_i,
  input  logic [ADDR_W-1:0]  alloc_pc_i,
  input  logic               fill_i,
  input  logic [INSTR_W-1:0] fill_instr_i,
  input  logic               pop_i,
  output logic               head_valid_o,
  output logic [ADDR_W-1:0]  head_pc_o,
  output logic [INSTR_W-1:0] head_instr_o,
  output logic [PtrW-1:0]    count_o,
  output logic [PtrW-1:0]    inflight_o
);

  localparam int unsigned IdxW = PtrW - 1;

  fetch_entry_t    slots_q [Depth];
  fetch_entry_t    slots_d [Depth];
  logic [PtrW-1:0] alloc_q, alloc_d;
  logic [PtrW-1:0] fill_q, fill_d;
  logic [PtrW-1:0] rd_q, rd_d;
  logic [IdxW-1:0] alloc_idx, fill_idx, rd_idx;

  assign alloc_idx = alloc_q[IdxW-1:0];
  assign fill_idx  = fill_q[IdxW-1:0];
  assign rd_idx    = rd_q[IdxW-1:0];

  always_comb begin
    slots_d = slots_q;
    alloc_d = alloc_q;
    fill_d  = fill_q;
    rd_d    = rd_q;
    if (alloc_i) begin
      slots_d[alloc_idx].pc     = alloc_pc_i;
      slots_d[alloc_idx].instr  = NOP_INSTR;
      slots_d[alloc_idx].filled = 1'b0;
      alloc_d                   = alloc_q + PtrW'(1);
    end
    if (fill_i) begin
      slots_d[fill_idx].instr  = fill_instr_i;
      slots_d[fill_idx].filled = 1'b1;
      fill_d                   = fill_q + PtrW'(1);
    end
    // Pop after fill: a slot filled and consumed in one cycle ends up clear.
    if (pop_i) begin
      slots_d[rd_idx].filled = 1'b0;
      rd_d                   = rd_q + PtrW'(1);
    end
    if (flush_i) begin
      alloc_d = '0;
      fill_d  = '0;
      rd_d    = '0;
      for (int i = 0; i < int'(Depth); i++) begin
        slots_d[i].filled = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        slots_q[i] <= '0;
      end
      alloc_q <= '0;
      fill_q  <= '0;
      rd_q    <= '0;
    end else begin
      slots_q <= slots_d;
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      rd_q    <= rd_d;
    end
  end

  assign head_valid_o = slots_q[rd_idx].filled && (alloc_q != rd_q);
  assign head_pc_o    = slots_q[rd_idx].pc;
  assign head_instr_o = slots_q[rd_idx].instr;
  assign count_o      = alloc_q - rd_q;
  assign inflight_o   = alloc_q - fill_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage: PC, request gating, wrong-path discard and the fetch queue.
// Optional FETCH_BYPASS_EN forwards a response straight to ID when the queue is empty.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned       QUEUE_DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               imem_req_valid_o,
  input  logic               imem_req_ready_i,
  output logic [ADDR_W-1:0]  imem_req_addr_o,
  input  logic               imem_rsp_valid_i,
  input  logic [INSTR_W-1:0] imem_rsp_data_i,
  input  logic               redirect_valid_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               id_valid_o,
  input  logic               id_ready_i,
  output logic [INSTR_W-1:0] id_instr_o,
  output logic [ADDR_W-1:0]  id_pc_o,
  output logic [ADDR_W-1:0]  id_pc_plus4_o
);

  localparam int unsigned     PtrW     = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [PtrW-1:0] DepthCnt = PtrW'(QUEUE_DEPTH);
  localparam int unsigned     DiscW    = 8;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [DiscW-1:0]   discard_q, discard_d;
  logic               req_fire, rsp_drop, rsp_write, pop, bypass;
  logic               head_valid;
  logic [ADDR_W-1:0]  head_pc;
  logic [INSTR_W-1:0] head_instr;
  logic [PtrW-1:0]    count, inflight;

  assign imem_req_valid_o = !rst_i && !redirect_valid_i && (count < DepthCnt);
  assign imem_req_addr_o  = pc_q;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign rsp_drop  = redirect_valid_i || (discard_q != '0) || (inflight == '0);
  assign rsp_write = imem_rsp_valid_i && !rsp_drop;

`ifdef FETCH_BYPASS_EN
  // count == inflight means rd == fill: no filled entry is waiting ahead of this one.
  assign bypass = rsp_write && (count == inflight);
`else
  assign bypass = 1'b0;
`endif

  assign id_valid_o    = head_valid || bypass;
  assign id_pc_o       = id_valid_o ? head_pc : '0;
  assign id_pc_plus4_o = id_pc_o + 32'd4;
  assign pop           = id_valid_o && id_ready_i;

  always_comb begin
    id_instr_o = NOP_INSTR;
    if (head_valid) begin
      id_instr_o = head_instr;
    end else if (bypass) begin
      id_instr_o = imem_rsp_data_i;
    end
  end

  always_comb begin
    pc_d      = pc_q;
    discard_d = discard_q;
    if (redirect_valid_i) begin
      pc_d = redirect_pc_i & 32'hFFFF_FFFC;
      // Pending discards are kept; a response arriving now is dropped and retires one.
      discard_d = discard_q + DiscW'(inflight)
                - DiscW'(imem_rsp_valid_i && ((discard_q != '0) || (inflight != '0)));
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 32'd4;
      end
      if (imem_rsp_valid_i && (discard_q != '0)) begin
        discard_d = discard_q - DiscW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q      <= RESET_PC;
      discard_q <= '0;
    end else begin
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

  fetch_queue #(
    .Depth(QUEUE_DEPTH)
  ) u_queue (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (redirect_valid_i),
    .alloc_i      (req_fire),
    .alloc_pc_i   (pc_q),
    .fill_i       (rsp_write),
    .fill_instr_i (imem_rsp_data_i),
    .pop_i        (pop),
    .head_valid_o (head_valid),
    .head_pc_o    (head_pc),
    .head_instr_o (head_instr),
    .count_o      (count),
    .inflight_o   (inflight)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order variable-latency memory model, an expected-stream
// model checked every cycle, and directed scenarios with literal expectations.
module tb_fetch_stage;
  import cpu_pkg::*;

  localparam int DEPTH = 2;
`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc, id_pc_plus4;

  fetch_stage #(
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .imem_req_valid_o (req_valid),
    .imem_req_ready_i (req_ready),
    .imem_req_addr_o  (req_addr),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rsp_data_i  (rsp_data),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .id_valid_o       (id_valid),
    .id_ready_i       (id_ready),
    .id_instr_o       (id_instr),
    .id_pc_o          (id_pc),
    .id_pc_plus4_o    (id_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int mem_lat  = 1;
  int rel_cyc  = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  logic [31:0] acc_addr[$];
  logic [31:0] acc_cyc[$];
  logic [31:0] del_pc[$];
  logic [31:0] del_p4[$];
  logic [31:0] del_cyc[$];

  // Model state: next fetch address, next PC the ID stage must see, and queue occupancy.
  logic [31:0] m_pc;
  logic [31:0] exp_pc;
  int          occ;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0001;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hBAD0_BAD0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, want %08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory: answers each accepted request exactly mem_lat cycles later, in order.
  initial begin
    rsp_valid = 1'b0;
    rsp_data  = 32'h0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (mq.size() > 0 && mq[0].due == cyc) begin
        rsp_valid = 1'b1;
        rsp_data  = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        rsp_valid = 1'b0;
        rsp_data  = 32'h0;
      end
    end
  end

  // Compare process: checks outputs against the model every cycle, then advances it.
  initial begin
    logic acc, hs;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_pc   = 32'h0;
        exp_pc = 32'h0;
        occ    = 0;
        mq.delete();
        chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
      end else begin
        acc = req_valid && req_ready;
        hs  = id_valid && id_ready;
        chk("req_valid", {31'b0, req_valid}, {31'b0, (!redirect_valid && occ < DEPTH)});
        if (req_valid) chk("req_addr", req_addr, m_pc);
        if (id_valid) begin
          chk("id_pc", id_pc, exp_pc);
          chk("id_instr", id_instr, mem_word(exp_pc));
          chk("id_pc_plus4", id_pc_plus4, exp_pc + 32'd4);
        end else begin
          chk("idle_pc", id_pc, 32'h0);
          chk("idle_pc_plus4", id_pc_plus4, 32'h4);
          chk("idle_instr", id_instr, NOP_INSTR);
        end
        if (acc) begin
          mq.push_back('{addr: req_addr, due: cyc + mem_lat});
          acc_addr.push_back(req_addr);
          acc_cyc.push_back(32'(cyc));
        end
        if (hs) begin
          del_pc.push_back(id_pc);
          del_p4.push_back(id_pc_plus4);
          del_cyc.push_back(32'(cyc));
          exp_pc = exp_pc + 32'd4;
          occ--;
        end
        if (acc) begin
          m_pc = m_pc + 32'd4;
          occ++;
        end
        if (redirect_valid) begin
          m_pc   = redirect_pc & 32'hFFFF_FFFC;
          exp_pc = m_pc;
          occ    = 0;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    acc_addr.delete();
    acc_cyc.delete();
    del_pc.delete();
    del_p4.delete();
    del_cyc.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 of the first cycle with rst low.
  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    #1;
    chk("async_rst_req_valid", {31'b0, req_valid}, 32'd0);
    chk("async_rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("async_rst_id_pc", id_pc, 32'h0);
    chk("async_rst_id_pc_plus4", id_pc_plus4, 32'h4);
    chk("async_rst_id_instr", id_instr, 32'h0);
    step(2);
    rst     = 1'b0;
    rel_cyc = cyc;
    clear_logs();
  endtask

  initial begin
    rst            = 1'b1;
    req_ready      = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    @(posedge clk);
    #1;

    // Sequential fetch from reset, L=1. Depth 2 without bypass leaves a bubble before 8.
    mem_lat = 1;
    do_reset();
    step(8);
    chk("t1_first_req_cycle", qget(acc_cyc, 0), 32'(rel_cyc));
    chk("t1_req0", qget(acc_addr, 0), 32'h0);
    chk("t1_req1", qget(acc_addr, 1), 32'h4);
    chk("t1_req2", qget(acc_addr, 2), 32'h8);
    chk("t1_id0", qget(del_pc, 0), 32'h0);
    chk("t1_id1", qget(del_pc, 1), 32'h4);
    chk("t1_id2", qget(del_pc, 2), 32'h8);
    chk("t1_latency", qget(del_cyc, 0) - qget(acc_cyc, 0), 32'(2 - BYP));
    chk("t1_gap01", qget(del_cyc, 1) - qget(del_cyc, 0), 32'd1);
    chk("t1_gap02", qget(del_cyc, 2) - qget(del_cyc, 0), 32'(3 - BYP));

    // Back-pressure: exactly two requests, then stall until ID drains.
    id_ready = 1'b0;
    do_reset();
    step(6);
    chk("t2_accept_count", 32'(acc_addr.size()), 32'd2);
    chk("t2_req0", qget(acc_addr, 0), 32'h0);
    chk("t2_req1", qget(acc_addr, 1), 32'h4);
    chk("t2_stalled", {31'b0, req_valid}, 32'd0);
    chk("t2_head_pc", id_pc, 32'h0);
    id_ready = 1'b1;
    step(6);
    chk("t2_id0", qget(del_pc, 0), 32'h0);
    chk("t2_id1", qget(del_pc, 1), 32'h4);
    chk("t2_resume", qget(acc_addr, 2), 32'h8);

    // L=3 redirect with two requests in flight: both old responses must be dropped.
    mem_lat = 3;
    do_reset();
    step(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step(1);
    redirect_valid = 1'b0;
    step(10);
    chk("t3_new_req", qget(acc_addr, 2), 32'h100);
    chk("t3_new_req_cycle", qget(acc_cyc, 2), 32'(rel_cyc + 3));
    chk("t3_id0", qget(del_pc, 0), 32'h100);
    chk("t3_id1", qget(del_pc, 1), 32'h104);
    chk("t3_latency", qget(del_cyc, 0) - qget(acc_cyc, 2), 32'(4 - BYP));

    // Redirect together with a response and a handshake; 0x203 aligns to 0x200.
    mem_lat = 1;
    do_reset();
    step(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
`ifndef FETCH_BYPASS_EN
    #1;
    chk("t4_hs_same_cycle", {31'b0, id_valid}, 32'd1);
    chk("t4_hs_pc", id_pc, 32'h0);
`endif
    step(1);
    redirect_valid = 1'b0;
    step(8);
    chk("t4_id0_once", qget(del_pc, 0), 32'h0);
    chk("t4_id1", qget(del_pc, 1), 32'h200);
    chk("t4_id2", qget(del_pc, 2), 32'h204);
    chk("t5_aligned_req", qget(acc_addr, 2), 32'h200);
    chk("t5_req_cycle", qget(acc_cyc, 2), 32'(rel_cyc + 3));
    chk("t4_no_extra_discard", qget(del_cyc, 1) - qget(acc_cyc, 2), 32'(2 - BYP));

    // PC wrap through 0xFFFF_FFFC; in-flight old-path responses get discarded.
    clear_logs();
    id_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step(1);
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    step(8);
    chk("t6_req0", qget(acc_addr, 0), 32'hFFFF_FFFC);
    chk("t6_req1", qget(acc_addr, 1), 32'h0000_0000);
    chk("t6_id0", qget(del_pc, 0), 32'hFFFF_FFFC);
    chk("t6_id0_plus4", qget(del_p4, 0), 32'h0000_0000);
    chk("t6_id1", qget(del_pc, 1), 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
